// File: rtl/codec_cfg_scheduler.sv
// ----------------------------------------------------------------------------
// codec_cfg_scheduler
//   Issues the codec boot configuration (11-word ROM) to a downstream I2C write
//   engine, then serves runtime register-write requests. Every word is retried
//   on NACK or timeout up to MAX_RETRY times, and each completed attempt is
//   followed by GAP_CYCLES idle cycles.
//
// Ports
//   i_clk, i_rst_n            clock, async active-low reset
//   i_start                   request (re)start of the boot sequence
//   i_req_valid/i_req_data    runtime write request {7b addr, 9b value}
//   o_req_ready               request accepted when high with i_req_valid
//   o_wr_start/o_wr_data      one-cycle command + word to the write engine
//   i_wr_done/i_wr_ack_ok     engine completion pulse and ACK status
//   o_busy/o_init_done/o_error  status (all registered)
// ----------------------------------------------------------------------------
module codec_cfg_scheduler #(
    parameter int MAX_RETRY      = 3,
    parameter int GAP_CYCLES     = 4,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  logic        i_req_valid,
    input  logic [15:0] i_req_data,
    output logic        o_req_ready,
    output logic        o_wr_start,
    output logic [15:0] o_wr_data,
    input  logic        i_wr_done,
    input  logic        i_wr_ack_ok,
    output logic        o_busy,
    output logic        o_init_done,
    output logic        o_error
);

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_INIT_ISSUE = 3'd1;
    localparam logic [2:0] S_INIT_WAIT  = 3'd2;
    localparam logic [2:0] S_GAP        = 3'd3;
    localparam logic [2:0] S_RUN_IDLE   = 3'd4;
    localparam logic [2:0] S_RUN_ISSUE  = 3'd5;
    localparam logic [2:0] S_RUN_WAIT   = 3'd6;
    localparam logic [2:0] S_ERROR      = 3'd7;

    localparam logic [3:0] ROM_LEN = 4'd11;

    function automatic logic [15:0] rom_word(input logic [3:0] idx);
        case (idx)
            4'd0:    rom_word = 16'h1E00;
            4'd1:    rom_word = 16'h0097;
            4'd2:    rom_word = 16'h0297;
            4'd3:    rom_word = 16'h0479;
            4'd4:    rom_word = 16'h0679;
            4'd5:    rom_word = 16'h0815;
            4'd6:    rom_word = 16'h0A00;
            4'd7:    rom_word = 16'h0C00;
            4'd8:    rom_word = 16'h0E42;
            4'd9:    rom_word = 16'h1019;
            4'd10:   rom_word = 16'h1201;
            default: rom_word = 16'h0000;
        endcase
    endfunction

    logic [2:0]  state, state_nxt;
    logic [3:0]  rom_idx;
    logic [7:0]  retry_cnt;
    logic [15:0] wait_cnt;
    logic [7:0]  gap_cnt;
    logic        in_run;     // current word is a runtime request, not boot ROM
    logic        last_ok;    // outcome of the attempt that started this GAP
    logic [15:0] req_word;

    logic        start_seq, accept, wr_ok, wr_fail, timeout;
    logic [15:0] issue_word;

    assign timeout = (wait_cnt == 16'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_nxt = state;
        start_seq = 1'b0;
        accept    = 1'b0;
        wr_ok     = 1'b0;
        wr_fail   = 1'b0;
        case (state)
            S_IDLE:       if (i_start) start_seq = 1'b1;
            S_INIT_ISSUE: state_nxt = S_INIT_WAIT;
            S_RUN_ISSUE:  state_nxt = S_RUN_WAIT;
            S_INIT_WAIT, S_RUN_WAIT: begin
                if (i_wr_done && i_wr_ack_ok) begin
                    wr_ok     = 1'b1;
                    state_nxt = S_GAP;
                end else if (i_wr_done || timeout) begin
                    wr_fail   = 1'b1;
                    state_nxt = (retry_cnt == 8'(MAX_RETRY)) ? S_ERROR : S_GAP;
                end
            end
            S_GAP: begin
                if (gap_cnt == 8'(GAP_CYCLES - 1)) begin
                    if (in_run)
                        state_nxt = last_ok ? S_RUN_IDLE : S_RUN_ISSUE;
                    else if (rom_idx == ROM_LEN)
                        state_nxt = S_RUN_IDLE;
                    else
                        state_nxt = S_INIT_ISSUE;
                end
            end
            S_RUN_IDLE: begin
                if (i_start) begin
                    start_seq = 1'b1;
                end else if (i_req_valid) begin
                    accept    = 1'b1;
                    state_nxt = S_RUN_ISSUE;
                end
            end
            S_ERROR:      if (i_start) start_seq = 1'b1;
            default:      state_nxt = S_IDLE;
        endcase
        if (start_seq) state_nxt = S_INIT_ISSUE;
    end

    // Word presented on the next ISSUE; a restart always begins at ROM entry 0.
    always_comb begin
        issue_word = o_wr_data;
        if (state_nxt == S_INIT_ISSUE)
            issue_word = start_seq ? rom_word(4'd0) : rom_word(rom_idx);
        else if (state_nxt == S_RUN_ISSUE)
            issue_word = accept ? i_req_data : req_word;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= S_IDLE;
            rom_idx     <= '0;
            retry_cnt   <= '0;
            wait_cnt    <= '0;
            gap_cnt     <= '0;
            in_run      <= 1'b0;
            last_ok     <= 1'b0;
            req_word    <= '0;
            o_wr_start  <= 1'b0;
            o_wr_data   <= '0;
            o_req_ready <= 1'b0;
            o_busy      <= 1'b0;
            o_init_done <= 1'b0;
            o_error     <= 1'b0;
        end else begin
            state <= state_nxt;

            // Outputs are registered copies of what the next state implies.
            o_wr_start  <= (state_nxt == S_INIT_ISSUE) || (state_nxt == S_RUN_ISSUE);
            o_req_ready <= (state_nxt == S_RUN_IDLE);
            o_busy      <= (state_nxt == S_INIT_ISSUE) || (state_nxt == S_INIT_WAIT) ||
                           (state_nxt == S_GAP) || (state_nxt == S_RUN_ISSUE) ||
                           (state_nxt == S_RUN_WAIT);
            o_wr_data   <= issue_word;

            if (start_seq) begin
                rom_idx     <= '0;
                retry_cnt   <= '0;
                in_run      <= 1'b0;
                o_init_done <= 1'b0;
                o_error     <= 1'b0;
            end

            if (accept) begin
                req_word  <= i_req_data;
                in_run    <= 1'b1;
                retry_cnt <= '0;
            end

            if ((state == S_INIT_ISSUE) || (state == S_RUN_ISSUE))
                wait_cnt <= '0;
            else if ((state == S_INIT_WAIT) || (state == S_RUN_WAIT))
                wait_cnt <= wait_cnt + 16'd1;

            if (state == S_GAP)
                gap_cnt <= gap_cnt + 8'd1;

            if (wr_ok) begin
                last_ok   <= 1'b1;
                retry_cnt <= '0;
                gap_cnt   <= '0;
                if (!in_run) rom_idx <= rom_idx + 4'd1;
            end

            if (wr_fail) begin
                last_ok <= 1'b0;
                gap_cnt <= '0;
                if (retry_cnt != 8'(MAX_RETRY)) retry_cnt <= retry_cnt + 8'd1;
                else                            o_error   <= 1'b1;
            end

            if ((state == S_GAP) && (state_nxt == S_RUN_IDLE) && !in_run)
                o_init_done <= 1'b1;
        end
    end

endmodule
